// File: rtl/mdu_ctrl.sv
// Issue controller for the multiply/divide unit: launches MDU operations,
// tracks occupancy with a down-counter and stalls dependent MDU instructions.
`timescale 1ns/1ps

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       OpValid,
    input  logic [3:0] Op,
    input  logic       Req,
    output logic       Start,
    output logic [3:0] MDUOP,
    output logic [3:0] Time,
    output logic [1:0] ReadHILO,
    output logic       Stall,
    output logic       Busy,
    output logic       Done
);

    // Occupancy counts are clamped into the 4-bit counter's usable range 1..15.
    localparam int MULT_CLAMP = (MULT_CYCLES < 1) ? 1 : ((MULT_CYCLES > 15) ? 15 : MULT_CYCLES);
    localparam int DIV_CLAMP  = (DIV_CYCLES  < 1) ? 1 : ((DIV_CYCLES  > 15) ? 15 : DIV_CYCLES);
    localparam logic [3:0] MULT_TIME = 4'(MULT_CLAMP);
    localparam logic [3:0] DIV_TIME  = 4'(DIV_CLAMP);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;

    logic is_mul;
    logic is_div;
    logic is_mt;
    logic is_mf;
    logic is_mdu;
    logic live;
    logic acc;

    always_comb begin
        is_mul = (Op == 4'd1) || (Op == 4'd2);
        is_div = (Op == 4'd3) || (Op == 4'd4);
        is_mt  = (Op == 4'd5) || (Op == 4'd6);
        is_mf  = (Op == 4'd7) || (Op == 4'd8);
        is_mdu = is_mul || is_div || is_mt || is_mf;
        // Outputs are combinational, so they must also be silenced while reset is held.
        live   = reset;
        acc    = live && OpValid && !Req && (state == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        Start      = 1'b0;
        MDUOP      = 4'd0;
        Time       = 4'd0;
        ReadHILO   = 2'b00;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (is_mul || is_div) begin
                        Start      = 1'b1;
                        MDUOP      = Op;
                        Time       = is_mul ? MULT_TIME : DIV_TIME;
                        next_state = RUN;
                        next_cnt   = is_mul ? MULT_TIME : DIV_TIME;
                    end else if (is_mt) begin
                        MDUOP = Op;
                    end else if (is_mf) begin
                        ReadHILO = (Op == 4'd7) ? 2'b10 : 2'b01;
                    end
                end
            end
            RUN: begin
                // Req does not stop the count: the issued operation already altered HI/LO.
                if (cnt <= 4'd1) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        Stall = live && OpValid && !Req && (state == RUN) && is_mdu;
        Busy  = (state == RUN) || Start;
        Done  = (state == RUN) && (cnt == 4'd1);
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl; a second instance with a
// single-cycle multiply covers the minimum-occupancy corner.
`timescale 1ns/1ps

module tb_mdu_ctrl;

    logic       clk;
    logic       reset;
    logic       OpValid;
    logic [3:0] Op;
    logic       Req;

    logic       Start,  Start1;
    logic [3:0] MDUOP,  MDUOP1;
    logic [3:0] Time,   Time1;
    logic [1:0] ReadHILO, ReadHILO1;
    logic       Stall,  Stall1;
    logic       Busy,   Busy1;
    logic       Done,   Done1;

    typedef struct packed {
        logic       start;
        logic [3:0] mdu;
        logic [3:0] tm;
        logic [1:0] rh;
        logic       stall;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   stepNo = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .OpValid(OpValid), .Op(Op), .Req(Req),
        .Start(Start), .MDUOP(MDUOP), .Time(Time), .ReadHILO(ReadHILO),
        .Stall(Stall), .Busy(Busy), .Done(Done)
    );

    mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(10)) dut1 (
        .clk(clk), .reset(reset), .OpValid(OpValid), .Op(Op), .Req(Req),
        .Start(Start1), .MDUOP(MDUOP1), .Time(Time1), .ReadHILO(ReadHILO1),
        .Stall(Stall1), .Busy(Busy1), .Done(Done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT must show for it.
    task automatic applyStimulus(input logic ov, input logic [3:0] op, input logic rq,
                                 input logic eStart, input logic [3:0] eMdu,
                                 input logic [3:0] eTime, input logic [1:0] eRh,
                                 input logic eStall, input logic eBusy, input logic eDone);
        exp_t e;
        OpValid = ov;
        Op      = op;
        Req     = rq;
        e.start = eStart;
        e.mdu   = eMdu;
        e.tm    = eTime;
        e.rh    = eRh;
        e.stall = eStall;
        e.busy  = eBusy;
        e.done  = eDone;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        stepNo++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL s%0d.queue observed empty expected entry", stepNo);
        end else begin
            e = sb.pop_front();
            chk($sformatf("s%0d.Start", stepNo),    {3'b0, Start}, {3'b0, e.start});
            chk($sformatf("s%0d.MDUOP", stepNo),    MDUOP,         e.mdu);
            chk($sformatf("s%0d.Time", stepNo),     Time,          e.tm);
            chk($sformatf("s%0d.ReadHILO", stepNo), {2'b0, ReadHILO}, {2'b0, e.rh});
            chk($sformatf("s%0d.Stall", stepNo),    {3'b0, Stall}, {3'b0, e.stall});
            chk($sformatf("s%0d.Busy", stepNo),     {3'b0, Busy},  {3'b0, e.busy});
            chk($sformatf("s%0d.Done", stepNo),     {3'b0, Done},  {3'b0, e.done});
        end
    endtask

    task automatic step(input logic ov, input logic [3:0] op, input logic rq,
                        input logic eStart, input logic [3:0] eMdu,
                        input logic [3:0] eTime, input logic [1:0] eRh,
                        input logic eStall, input logic eBusy, input logic eDone);
        @(posedge clk);
        #1;
        applyStimulus(ov, op, rq, eStart, eMdu, eTime, eRh, eStall, eBusy, eDone);
        #4;
        checkOutput();
    endtask

    initial begin
        reset   = 1'b0;
        OpValid = 1'b1;
        Op      = 4'd1;
        Req     = 1'b0;

        // Held in reset with a mult presented: everything quiet.
        step(1, 4'd1, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);
        step(1, 4'd1, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);
        chk("r.Busy1", {3'b0, Busy1}, 4'd0);

        // Release reset mid-cycle: mult launches in that same cycle.
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1, 4'd1, 0, 1, 4'd1, 4'd5, 2'b00, 0, 1, 0);
        #4;
        checkOutput();
        chk("m1.Start1", {3'b0, Start1}, 4'd1);
        chk("m1.Time1", Time1, 4'd1);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        chk("m1.Busy1_t1", {3'b0, Busy1}, 4'd1);
        chk("m1.Done1_t1", {3'b0, Done1}, 4'd1);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        chk("m1.Busy1_t2", {3'b0, Busy1}, 4'd0);
        chk("m1.Done1_t2", {3'b0, Done1}, 4'd0);
        for (int i = 3; i <= 4; i++) step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 1);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);

        // div then mflo held: stalls through the whole occupancy, then reads LO.
        step(1, 4'd3, 0, 1, 4'd3, 4'd10, 2'b00, 0, 1, 0);
        for (int i = 1; i <= 9; i++) step(1, 4'd8, 0, 0, 4'd0, 4'd0, 2'b00, 1, 1, 0);
        step(1, 4'd8, 0, 0, 4'd0, 4'd0, 2'b00, 1, 1, 1);
        step(1, 4'd8, 0, 0, 4'd0, 4'd0, 2'b01, 0, 0, 0);

        // mthi in IDLE is a single-cycle write with no launch.
        step(1, 4'd5, 0, 0, 4'd5, 4'd0, 2'b00, 0, 0, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);

        // mthi during RUN stalls and is not forwarded.
        step(1, 4'd1, 0, 1, 4'd1, 4'd5, 2'b00, 0, 1, 0);
        step(1, 4'd5, 0, 0, 4'd0, 4'd0, 2'b00, 1, 1, 0);
        for (int i = 2; i <= 4; i++) step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 1);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);

        // multu with Req in IDLE: suppressed, state stays IDLE.
        step(1, 4'd2, 1, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);

        // Req during RUN drops the stall but not the count.
        step(1, 4'd1, 0, 1, 4'd1, 4'd5, 2'b00, 0, 1, 0);
        step(1, 4'd7, 0, 0, 4'd0, 4'd0, 2'b00, 1, 1, 0);
        step(1, 4'd7, 1, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 1);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);

        // Asynchronous reset pulse mid-RUN drops Busy with no clock edge.
        step(1, 4'd1, 0, 1, 4'd1, 4'd5, 2'b00, 0, 1, 0);
        for (int i = 1; i <= 3; i++) step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        reset = 1'b0;
        #1;
        applyStimulus(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);
        checkOutput();
        reset = 1'b1;

        // Fresh div right after; an undefined op during RUN never stalls.
        step(1, 4'd3, 0, 1, 4'd3, 4'd10, 2'b00, 0, 1, 0);
        step(1, 4'd9, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        for (int i = 2; i <= 9; i++) step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 0);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 1, 1);
        step(0, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);

        // Undefined codes in IDLE do nothing.
        step(1, 4'd9, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);
        step(1, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0);
        step(1, 4'd7, 0, 0, 4'd0, 4'd0, 2'b10, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
